dma_slave_mem: RTL and testbench
================================

# dma_slave_mem

Word-addressed memory responder for the `dma_master` read/write address, data and response channels, using the same handshake signal set. It serves as both the DMA source and the destination memory in block-level and system benches, and as a small on-chip scratch memory. It handles one outstanding read and one outstanding write independently, with a programmable read latency. A debug port and transaction counters give the bench visibility into memory contents and traffic.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, 2..256; IW = log2(DEPTH).
- RD_LATENCY, 1: cycles from AR handshake edge to RVALID rising; legal range 1..15.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accept.
- ARADDR  in  32  byte address; word index = ARADDR[IW+1:2].
- RVALID  out  1  read data valid.
- RREADY  in  1  read data accept.
- RDATA  out  32  read data.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accept.
- AWADDR  in  32  byte address; word index = AWADDR[IW+1:2].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accept.
- WDATA  in  32  write data.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response accept.
- dbg_index  in  IW  debug word index.
- dbg_data  out  32  combinational mem[dbg_index].
- rd_count  out  8  completed R handshakes, wraps 255->0.
- wr_count  out  8  completed B handshakes, wraps 255->0.

## Operation
- A handshake completes on a rising edge where VALID and READY are both 1.
- Address decode: ARADDR[1:0] and AWADDR[1:0] are ignored. Bits above IW+1 are ignored, so addresses wrap modulo DEPTH*4.
- Read FSM states:
  - R_IDLE: ARREADY=1. An AR handshake latches the index, drives ARREADY<=0, loads the latency counter with RD_LATENCY-1, and moves to R_WAIT.
  - R_WAIT: the counter decrements each cycle. At 0, RDATA<=mem[index] and RVALID<=1, and the FSM moves to R_DATA. With RD_LATENCY=1 this happens on the first cycle after acceptance.
  - R_DATA: RVALID and RDATA are held stable until the R handshake. The handshake edge drives RVALID<=0, ARREADY<=1, increments rd_count, and returns to R_IDLE.
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=0. An AW handshake latches the index, drives AWREADY<=0 and WREADY<=1, and moves to W_DATA.
  - W_DATA: a W handshake writes mem[index]<=WDATA, drives WREADY<=0 and BVALID<=1, and moves to W_RESP.
  - W_RESP: BVALID is held until the B handshake. The handshake edge drives BVALID<=0, AWREADY<=1, increments wr_count, and returns to W_IDLE.
- WVALID asserted before the AW handshake is not accepted; WREADY stays 0 until W_DATA.
- The read and write FSMs run concurrently and never stall each other.

## Timing
- Reset values: ARREADY=1, AWREADY=1, RVALID=0, BVALID=0, WREADY=0, RDATA=0, rd_count=0, wr_count=0, all memory words 0. Both FSMs return to their IDLE states.
- Reset asserted mid-transaction aborts the transaction. No response is issued after reset is released.
- Read latency: RVALID rises exactly RD_LATENCY cycles after the AR handshake edge.
- Minimum read turnaround is RD_LATENCY+2 cycles from one AR handshake to the next, when RREADY is held high.
- Write: WREADY rises 1 cycle after the AW handshake. BVALID rises 1 cycle after the W handshake. AWREADY returns 1 cycle after the B handshake.
- Read/write collision: if a write commits to index k on the same edge that RDATA samples mem[k], RDATA returns the old value. A read sampled any later edge returns the new value.
- dbg_data reflects a write one cycle after the W handshake edge.
- Counters wrap silently; they do not saturate.

## Test plan
- Reset defaults: assert reset asynchronously mid-cycle -> all outputs take their reset values immediately; dbg_data=0 for every index.
- Write then read, RD_LATENCY=1: AW 0x0000_0008, WDATA 0xDEAD_BEEF, then AR 0x0000_0008 -> RVALID one cycle after AR acceptance, RDATA=0xDEAD_BEEF, wr_count=1, rd_count=1.
- Backpressure and latency, RD_LATENCY=4: hold RREADY=0 for 5 cycles after RVALID -> RVALID rises 4 cycles after acceptance and RDATA stays stable; BREADY low for 3 cycles -> BVALID stays high and AWREADY stays 0.
- Address wrap, DEPTH=16: write 0x1234_5678 to 0x0000_0040 -> dbg_index 0 reads 0x1234_5678; ARADDR 0x0000_0043 returns the same value.
- Concurrency and collision: simultaneous AR and AW to index 3 (old value 0xAAAA_AAAA, new 0x5555_5555), timed so the write commits on the RDATA sample edge -> RDATA=0xAAAA_AAAA and dbg_data=0x5555_5555.
- Full DMA: the DMA master copies 4 words from 0x00 to 0x20 -> words 8..11 equal words 0..3, rd_count=4, wr_count=4.

Source files
------------

// File: rtl/dma_slave_mem.sv
// dma_slave_mem
//   Word-addressed memory responder for the dma_master address/data/response
//   channels. One outstanding read and one outstanding write are handled
//   independently. Read data appears a programmable number of cycles after
//   the read address is accepted. A debug port and traffic counters give
//   visibility into memory contents and completed transactions.
//
// Parameters
//   DEPTH       number of 32-bit words (power of two, 2..256)
//   RD_LATENCY  cycles from AR handshake edge to RVALID rising (1..15)
//
// Ports
//   clk, reset                     clock, async active-high reset
//   ARVALID/ARREADY/ARADDR         read address channel (byte address)
//   RVALID/RREADY/RDATA            read data channel
//   AWVALID/AWREADY/AWADDR         write address channel (byte address)
//   WVALID/WREADY/WDATA            write data channel
//   BVALID/BREADY                  write response channel
//   dbg_index/dbg_data             combinational peek at mem[dbg_index]
//   rd_count/wr_count              completed R / B handshakes, wrapping
//
// Read FSM
//   state  | meaning
//   R_IDLE | ready for a read address
//   R_WAIT | latency countdown before sampling memory
//   R_DATA | RDATA/RVALID held until the R handshake
//
// Write FSM
//   state  | meaning
//   W_IDLE | ready for a write address
//   W_DATA | address latched, waiting for write data
//   W_RESP | BVALID held until the B handshake
module dma_slave_mem #(
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  input  logic [31:0]              ARADDR,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [31:0]              RDATA,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              AWADDR,
  input  logic                     WVALID,
  output logic                     WREADY,
  input  logic [31:0]              WDATA,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [$clog2(DEPTH)-1:0] dbg_index,
  output logic [31:0]              dbg_data,
  output logic [7:0]               rd_count,
  output logic [7:0]               wr_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [31:0]   mem [DEPTH];
  logic [3:0]    lat_cnt;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Byte-lane bits and bits above the word index are intentionally dropped,
  // so addresses wrap modulo DEPTH*4.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR[31:IW+2], ARADDR[1:0],
                              AWADDR[31:IW+2], AWADDR[1:0]};

  // Handshake outputs decode directly from the registered state, so each
  // one changes exactly on the state-transition edge.
  assign ARREADY = (rd_state == R_IDLE);
  assign RVALID  = (rd_state == R_DATA);
  assign AWREADY = (wr_state == W_IDLE);
  assign WREADY  = (wr_state == W_DATA);
  assign BVALID  = (wr_state == W_RESP);

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID  & RREADY;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign b_hs  = BVALID  & BREADY;

  assign dbg_data = mem[dbg_index];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_WAIT;
      R_WAIT:  if (lat_cnt == 4'd0) rd_next = R_DATA;
      R_DATA:  if (r_hs) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_hs) wr_next = W_RESP;
      W_RESP:  if (b_hs) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Read datapath. RDATA samples the array with old contents on the same
  // edge a write commits, giving read-before-write on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_idx  <= '0;
      lat_cnt <= '0;
      RDATA   <= '0;
    end else if (ar_hs) begin
      rd_idx  <= ARADDR[IW+1:2];
      lat_cnt <= LAT_INIT;
    end else if (rd_state == R_WAIT) begin
      if (lat_cnt == 4'd0) RDATA <= mem[rd_idx];
      else lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
    end else if (aw_hs) begin
      wr_idx <= AWADDR[IW+1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_hs) begin
      mem[wr_idx] <= WDATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (r_hs) rd_count <= rd_count + 8'd1;
      if (b_hs) wr_count <= wr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dma_slave_mem.sv
`timescale 1ns/1ps
module tb_dma_slave_mem;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int L     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ARVALID = 0, RREADY = 0, AWVALID = 0, WVALID = 0, BREADY = 0;
  logic [31:0]   ARADDR = 0, AWADDR = 0, WDATA = 0;
  logic [IW-1:0] dbg_index = 0;
  logic          ARREADY, RVALID, AWREADY, WREADY, BVALID;
  logic [31:0]   RDATA, dbg_data;
  logic [7:0]    rd_count, wr_count;

  dma_slave_mem #(.DEPTH(DEPTH), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY),
    .dbg_index(dbg_index), .dbg_data(dbg_data),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s wait bound expired at %0t", name, $time);
  endtask

  // Reference model: transaction-level view. A read is just "accepted at
  // edge t"; its data is due at edge t+L and taken from memory as it stood
  // before that edge. A write is address-accepted, data-accepted, responded.
  int            cyc = 0;
  logic [31:0]   m_mem [DEPTH];
  bit            m_rd_busy, m_rvalid, m_aw_busy, m_wready, m_bvalid;
  int            m_rd_t;
  logic [IW-1:0] m_rd_idx, m_wr_idx;
  logic [31:0]   m_rdata;
  logic [7:0]    m_rd_cnt, m_wr_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rd_busy <= 0; m_rvalid <= 0; m_aw_busy <= 0; m_wready <= 0; m_bvalid <= 0;
      m_rd_t <= 0; m_rd_idx <= '0; m_wr_idx <= '0; m_rdata <= '0;
      m_rd_cnt <= '0; m_wr_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      if (m_rvalid && RREADY) begin
        m_rvalid <= 0; m_rd_busy <= 0; m_rd_cnt <= m_rd_cnt + 8'd1;
      end else if (m_rd_busy && !m_rvalid) begin
        if (cyc == m_rd_t + L) begin
          m_rvalid <= 1; m_rdata <= m_mem[m_rd_idx];
        end
      end else if (!m_rd_busy && ARVALID) begin
        m_rd_busy <= 1; m_rd_t <= cyc; m_rd_idx <= ARADDR[IW+1:2];
      end
      if (m_bvalid && BREADY) begin
        m_bvalid <= 0; m_aw_busy <= 0; m_wr_cnt <= m_wr_cnt + 8'd1;
      end else if (m_wready && WVALID) begin
        m_wready <= 0; m_bvalid <= 1; m_mem[m_wr_idx] <= WDATA;
      end else if (!m_aw_busy && AWVALID) begin
        m_aw_busy <= 1; m_wready <= 1; m_wr_idx <= AWADDR[IW+1:2];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("arready",  {31'b0, ARREADY}, {31'b0, !m_rd_busy});
      chk("rvalid",   {31'b0, RVALID},  {31'b0, m_rvalid});
      chk("rdata",    RDATA, m_rdata);
      chk("awready",  {31'b0, AWREADY}, {31'b0, !m_aw_busy});
      chk("wready",   {31'b0, WREADY},  {31'b0, m_wready});
      chk("bvalid",   {31'b0, BVALID},  {31'b0, m_bvalid});
      chk("rd_count", {24'b0, rd_count}, {24'b0, m_rd_cnt});
      chk("wr_count", {24'b0, wr_count}, {24'b0, m_wr_cnt});
      chk("dbg_data", dbg_data, m_mem[dbg_index]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input int bhold);
    int n;
    AWVALID = 1; AWADDR = addr;
    n = 0;
    while (!AWREADY && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("awready");
    tick();
    AWVALID = 0; WVALID = 1; WDATA = data;
    n = 0;
    while (!WREADY && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("wready");
    tick();
    WVALID = 0; BREADY = 0;
    n = 0;
    while (!BVALID && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("bvalid");
    for (int k = 0; k < bhold; k++) begin
      chk("bvalid_held", {31'b0, BVALID}, 32'd1);
      chk("awready_low", {31'b0, AWREADY}, 32'd0);
      tick();
    end
    BREADY = 1;
    tick();
    BREADY = 0;
  endtask

  task automatic read_word(input logic [31:0] addr, input int rhold,
                           output logic [31:0] data, output int lat);
    int n;
    ARVALID = 1; ARADDR = addr;
    n = 0;
    while (!ARREADY && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("arready");
    tick();
    ARVALID = 0; RREADY = 0;
    lat = 0;
    while (!RVALID && lat < 50) begin tick(); lat++; end
    if (lat >= 50) timeout("rvalid");
    data = RDATA;
    for (int k = 0; k < rhold; k++) begin
      tick();
      chk("rvalid_held", {31'b0, RVALID}, 32'd1);
      chk("rdata_stable", RDATA, data);
    end
    RREADY = 1;
    tick();
    RREADY = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] src [4];
    int          lat;
    logic [7:0]  rc0, wc0;

    #1 reset = 1;
    repeat (3) tick();
    reset = 0;
    cmp_en = 1;
    tick();

    // Reset defaults: leave a write mid-response, then reset between edges.
    AWVALID = 1; AWADDR = 32'h0; tick();
    AWVALID = 0; WVALID = 1; WDATA = 32'hFFFF_FFFF; tick();
    WVALID = 0; ARVALID = 1; ARADDR = 32'h4; tick();
    ARVALID = 0;
    #1 reset = 1;
    #1;
    chk("rst_arready", {31'b0, ARREADY}, 32'd1);
    chk("rst_awready", {31'b0, AWREADY}, 32'd1);
    chk("rst_rvalid",  {31'b0, RVALID},  32'd0);
    chk("rst_bvalid",  {31'b0, BVALID},  32'd0);
    chk("rst_wready",  {31'b0, WREADY},  32'd0);
    chk("rst_rdata",   RDATA, 32'd0);
    chk("rst_counts",  {16'b0, rd_count, wr_count}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      dbg_index = IW'(i);
      #1 chk("rst_dbg_data", dbg_data, 32'd0);
    end
    tick();
    reset = 0;
    repeat (3) tick();
    chk("post_rst_no_resp", {30'b0, RVALID, BVALID}, 32'd0);

    // Write then read.
    write_word(32'h0000_0008, 32'hDEAD_BEEF, 0);
    chk("model_mem2", m_mem[2], 32'hDEAD_BEEF);
    read_word(32'h0000_0008, 0, d, lat);
    chk("rd_deadbeef", d, 32'hDEAD_BEEF);
    chk("rd_latency", lat, L);
    tick();
    chk("wr_count_1", {24'b0, wr_count}, 32'd1);
    chk("rd_count_1", {24'b0, rd_count}, 32'd1);

    // Backpressure on both response channels.
    write_word(32'h0000_0010, 32'hCAFE_0004, 3);
    read_word(32'h0000_0010, 5, d, lat);
    chk("bp_rdata", d, 32'hCAFE_0004);
    chk("bp_latency", lat, L);

    // Address wrap.
    write_word(32'h0000_0040, 32'h1234_5678, 0);
    dbg_index = '0;
    #1 chk("wrap_dbg0", dbg_data, 32'h1234_5678);
    chk("model_mem0", m_mem[0], 32'h1234_5678);
    read_word(32'h0000_0043, 0, d, lat);
    chk("wrap_rd43", d, 32'h1234_5678);

    // Collision: write to index 3 commits on the edge RDATA samples it.
    write_word(32'h0000_000C, 32'hAAAA_AAAA, 0);
    ARVALID = 1; ARADDR = 32'h0000_000C; tick();
    ARVALID = 0; tick(); tick();
    AWVALID = 1; AWADDR = 32'h0000_000C; tick();
    AWVALID = 0; WVALID = 1; WDATA = 32'h5555_5555; tick();
    WVALID = 0; dbg_index = 4'd3;
    #1;
    chk("coll_rvalid", {31'b0, RVALID}, 32'd1);
    chk("coll_rdata_old", RDATA, 32'hAAAA_AAAA);
    chk("coll_dbg_new", dbg_data, 32'h5555_5555);
    BREADY = 1; RREADY = 1; tick();
    BREADY = 0; RREADY = 0;
    read_word(32'h0000_000C, 0, d, lat);
    chk("coll_rd_after", d, 32'h5555_5555);

    // Copy 4 words from 0x00 to 0x20 the way the DMA master would.
    for (int i = 0; i < 4; i++) begin
      src[i] = $urandom;
      write_word(32'(i * 4), src[i], 0);
    end
    rc0 = rd_count; wc0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      read_word(32'(i * 4), 0, d, lat);
      write_word(32'h20 + 32'(i * 4), d, 0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_index = IW'(8 + i);
      #1 chk("dma_copy", dbg_data, src[i]);
    end
    chk("dma_rd_delta", {24'b0, 8'(rd_count - rc0)}, 32'd4);
    chk("dma_wr_delta", {24'b0, 8'(wr_count - wc0)}, 32'd4);

    // Randomized traffic on all channels, with one reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      tick();
      reset     = (c == 900);
      ARVALID   = 1'($urandom_range(0, 1));
      ARADDR    = $urandom;
      RREADY    = 1'($urandom_range(0, 1));
      AWVALID   = 1'($urandom_range(0, 1));
      AWADDR    = $urandom;
      WVALID    = 1'($urandom_range(0, 1));
      WDATA     = $urandom;
      BREADY    = 1'($urandom_range(0, 1));
      dbg_index = IW'($urandom_range(0, DEPTH - 1));
    end
    tick();
    reset = 0; ARVALID = 0; AWVALID = 0; WVALID = 0; RREADY = 0; BREADY = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
